usb_tx_scheduler: RTL

Transaction scheduler in front of the USB transmit control unit. Arbitrates between two 64-bit payload requesters (encrypted-data channel 0, status channel 1), latches the winning payload, and launches one token/data/handshake transaction. Waits for the handshake acknowledge, with a timeout and bounded retry. Sits between the encryptor output stage and the transmit control unit. It drives that unit's `trans_data_ready` and `trans_data`, and consumes its `handshake_ack` and `idle_transmitting`.

---
 rtl/usb_tx_scheduler_pkg.sv | 20 ++
 rtl/usb_tx_scheduler_rr_arb2.sv | 21 ++
 rtl/usb_tx_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/usb_tx_scheduler_pkg.sv
// Shared types and defaults for the USB transmit scheduler.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    RETRY,
    DONE,
    FAIL
  } state_t;

  // Requester indices: encrypted-data channel and status channel
  localparam int unsigned REQ_DATA   = 0;
  localparam int unsigned REQ_STATUS = 1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEFAULT_MAX_RETRIES    = 3;

endpackage

// File: rtl/usb_tx_scheduler_rr_arb2.sv
// Combinational two-way round-robin pick; the last-served index is held by the caller.
module rr_arb2
  import usb_tx_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] win
);

  // On contention the requester that was not served last wins
  always_comb begin
    win = '0;
    if (req[REQ_DATA] && req[REQ_STATUS]) begin
      win[REQ_DATA]   = last_served;
      win[REQ_STATUS] = ~last_served;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Transaction scheduler: arbitrates two payload requesters, launches one
// transaction to the transmit control unit, waits for ack with timeout/retry.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  req,
  input  logic [63:0] req_data0,
  input  logic [63:0] req_data1,
  output logic [1:0]  grant,
  output logic        trans_data_ready,
  output logic [63:0] trans_data,
  input  logic        idle_transmitting,
  input  logic        handshake_ack,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic        done_id
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timeout_cnt;
  logic [RW-1:0] retry_cnt;
  logic          retrying;
  logic          sel;
  logic          last_served;
  logic [1:0]    win;
  logic          launch;

  rr_arb2 u_arb (
    .req         (req),
    .last_served (last_served),
    .win         (win)
  );

  assign launch  = (state == IDLE) && (|req) && idle_transmitting;
  assign done_id = sel;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; ack takes priority over the final timeout cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (launch) state_nx = START;
      START:    state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (handshake_ack)            state_nx = DONE;
        else if (timeout_cnt == T_LAST) state_nx = (retry_cnt < R_MAX) ? RETRY : FAIL;
      end
      RETRY:    if (idle_transmitting) state_nx = START;
      DONE:     state_nx = IDLE;
      FAIL:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Moore output decode; grant is suppressed on retried launches
  always_comb begin
    grant            = '0;
    trans_data_ready = 1'b0;
    done             = 1'b0;
    fail             = 1'b0;
    busy             = (state != IDLE);
    case (state)
      START: begin
        trans_data_ready = 1'b1;
        if (!retrying) grant[sel] = 1'b1;
      end
      DONE:    done = 1'b1;
      FAIL:    fail = 1'b1;
      default: ;
    endcase
  end

  // Payload capture, arbitration history, timeout and retry bookkeeping
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      trans_data  <= '0;
      sel         <= 1'b0;
      last_served <= 1'b1;
      timeout_cnt <= '0;
      retry_cnt   <= '0;
      retrying    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            trans_data  <= win[REQ_STATUS] ? req_data1 : req_data0;
            sel         <= win[REQ_STATUS];
            last_served <= win[REQ_STATUS];
            retry_cnt   <= '0;
            retrying    <= 1'b0;
          end
        end
        START:    timeout_cnt <= '0;
        WAIT_ACK: begin
          if (!handshake_ack && (timeout_cnt != T_LAST))
            timeout_cnt <= timeout_cnt + TW'(1);
        end
        RETRY: begin
          if (idle_transmitting) begin
            retry_cnt <= retry_cnt + RW'(1);
            retrying  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
